// File: rtl/can_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | can_defs : shared CAN timing types, FSM encoding and bus-on constants       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package can_defs;

    localparam int CAN_INTEG_BITS    = 11;
    localparam int CAN_RECOVERY_SEQS = 128;

    typedef struct packed {
        logic [3:0] tseg1;
        logic [2:0] tseg2;
        logic [1:0] sjw;
        logic [5:0] baud_prescaler;
    } type_reg2tim_s;

    typedef enum logic [1:0] {
        ST_RESET_MODE      = 2'd0,
        ST_INTEGRATE       = 2'd1,
        ST_ACTIVE          = 2'd2,
        ST_BUS_OFF_RECOVER = 2'd3
    } type_btr_state_e;

    // sjw is zero-extended so every comparison is unsigned at field width
    function automatic logic btr_cfg_valid(input type_reg2tim_s c);
        return (c.tseg1 != 4'd0) && (c.tseg2 != 3'd0) &&
               ({1'b0, c.sjw} < c.tseg2) && ({2'b00, c.sjw} <= c.tseg1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_btr_ctrl_run_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | can_recessive_run_cnt : counts consecutive recessive samples, pulses at N   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module can_recessive_run_cnt
    import can_defs::*;
#(
    parameter int INTEG_BITS = CAN_INTEG_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_i,
    input  logic bit_i,
    input  logic clr_i,
    output logic run_done_o
);

    localparam int            CW   = $clog2(INTEG_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(INTEG_BITS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] run_cnt_q;
    logic [CW-1:0] run_cnt_d;

    // The counter restarts after each completed run so back-to-back runs count
    always_comb begin
        run_cnt_d  = run_cnt_q;
        run_done_o = 1'b0;
        if (clr_i) begin
            run_cnt_d = '0;
        end else if (sample_i) begin
            if (!bit_i) begin
                run_cnt_d = '0;
            end else if (run_cnt_q >= LAST) begin
                run_cnt_d  = '0;
                run_done_o = 1'b1;
            end else begin
                run_cnt_d = run_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/can_btr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | can_btr_ctrl : bit-timing shadow/commit and bus-on/bus-off recovery control |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module can_btr_ctrl
    import can_defs::*;
#(
    parameter int         INTEG_BITS    = CAN_INTEG_BITS,
    parameter int         RECOVERY_SEQS = CAN_RECOVERY_SEQS,
    parameter logic [3:0] RST_TSEG1     = 4'd5,
    parameter logic [2:0] RST_TSEG2     = 3'd2,
    parameter logic [1:0] RST_SJW       = 2'd0,
    parameter logic [5:0] RST_BRP       = 6'd4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_wr_i,
    input  type_reg2tim_s cfg_i,
    input  logic          reset_mode_i,
    input  logic          bus_off_i,
    input  logic          rx_idle_i,
    input  logic          transmitting_i,
    input  logic          sample_point_i,
    input  logic          sampled_bit_i,
    output type_reg2tim_s reg2tim_o,
    output logic          cfg_pending_o,
    output logic          cfg_err_o,
    output logic          bus_on_o,
    output logic          recovered_o,
    output logic [1:0]    state_o
);

    localparam int            SW       = $clog2(RECOVERY_SEQS + 1);
    localparam logic [SW-1:0] SEQ_LAST = SW'(RECOVERY_SEQS - 1);
    localparam logic [SW-1:0] SEQ_MAX  = SW'(RECOVERY_SEQS);
    localparam logic [SW-1:0] SEQ_ONE  = SW'(1);
    localparam type_reg2tim_s RST_CFG  = {RST_TSEG1, RST_TSEG2, RST_SJW, RST_BRP};

    type_btr_state_e state_q;
    type_reg2tim_s   shadow_q, shadow_d;
    type_reg2tim_s   active_q, active_d;
    logic            pending_q, pending_d;
    logic            cfg_err_q;
    logic            bus_on_q;
    logic            recovered_q;
    logic [SW-1:0]   seq_cnt_q;

    logic w_wr_ok;
    logic w_commit;
    logic w_run_clr;
    logic w_run_done;

    assign w_wr_ok   = cfg_wr_i & btr_cfg_valid(cfg_i);
    // Reset mode is always a safe point; otherwise only an idle, non-driving sample point
    assign w_commit  = pending_q & ((state_q == ST_RESET_MODE) | reset_mode_i |
                                    (sample_point_i & rx_idle_i & ~transmitting_i));
    assign w_run_clr = reset_mode_i |
                       ~((state_q == ST_INTEGRATE) | (state_q == ST_BUS_OFF_RECOVER));

    can_recessive_run_cnt #(
        .INTEG_BITS (INTEG_BITS)
    ) u_run_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_i   (sample_point_i),
        .bit_i      (sampled_bit_i),
        .clr_i      (w_run_clr),
        .run_done_o (w_run_done)
    );

    // A write landing on the commit cycle goes to the shadow; the old shadow commits
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (w_commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (w_wr_ok) begin
            shadow_d = cfg_i;
            if (state_q == ST_RESET_MODE) begin
                active_d  = cfg_i;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= RST_CFG;
            active_q  <= RST_CFG;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_wr_i & ~w_wr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_MODE;
            bus_on_q    <= 1'b0;
            recovered_q <= 1'b0;
            seq_cnt_q   <= '0;
        end else begin
            recovered_q <= 1'b0;
            if (reset_mode_i) begin
                state_q   <= ST_RESET_MODE;
                bus_on_q  <= 1'b0;
                seq_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_RESET_MODE: begin
                        state_q   <= ST_INTEGRATE;
                        seq_cnt_q <= '0;
                    end
                    ST_INTEGRATE: begin
                        if (w_run_done) begin
                            state_q  <= ST_ACTIVE;
                            bus_on_q <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (bus_off_i) begin
                            state_q   <= ST_BUS_OFF_RECOVER;
                            bus_on_q  <= 1'b0;
                            seq_cnt_q <= '0;
                        end
                    end
                    ST_BUS_OFF_RECOVER: begin
                        if (w_run_done) begin
                            if (seq_cnt_q >= SEQ_LAST) begin
                                seq_cnt_q   <= SEQ_MAX;
                                state_q     <= ST_ACTIVE;
                                bus_on_q    <= 1'b1;
                                recovered_q <= 1'b1;
                            end else begin
                                seq_cnt_q <= seq_cnt_q + SEQ_ONE;
                            end
                        end
                    end
                    default: state_q <= ST_RESET_MODE;
                endcase
            end
        end
    end

    assign reg2tim_o     = active_q;
    assign cfg_pending_o = pending_q;
    assign cfg_err_o     = cfg_err_q;
    assign bus_on_o      = bus_on_q;
    assign recovered_o   = recovered_q;
    assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_can_btr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_can_btr_ctrl : directed + random bench against a behavioural model       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_can_btr_ctrl;
    import can_defs::*;

    localparam int INTEG = 11;
    localparam int RECOV = 128;

    logic          clk;
    logic          rst_n;
    logic          cfg_wr;
    type_reg2tim_s cfg;
    logic          reset_mode;
    logic          bus_off;
    logic          rx_idle;
    logic          tx;
    logic          sp;
    logic          sbit;
    type_reg2tim_s reg2tim_o;
    logic          cfg_pending_o;
    logic          cfg_err_o;
    logic          bus_on_o;
    logic          recovered_o;
    logic [1:0]    state_o;

    can_btr_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_wr_i       (cfg_wr),
        .cfg_i          (cfg),
        .reset_mode_i   (reset_mode),
        .bus_off_i      (bus_off),
        .rx_idle_i      (rx_idle),
        .transmitting_i (tx),
        .sample_point_i (sp),
        .sampled_bit_i  (sbit),
        .reg2tim_o      (reg2tim_o),
        .cfg_pending_o  (cfg_pending_o),
        .cfg_err_o      (cfg_err_o),
        .bus_on_o       (bus_on_o),
        .recovered_o    (recovered_o),
        .state_o        (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_mism = 0;

    // Reference model state
    type_reg2tim_s m_sh, m_act;
    bit            m_pend, m_err, m_bus, m_rec;
    int            m_state, m_run, m_seq;

    type_reg2tim_s c_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mism++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal(input type_reg2tim_s c);
        int t1, t2, sj;
        t1 = int'(c.tseg1);
        t2 = int'(c.tseg2);
        sj = int'(c.sjw);
        return (t1 > 0) && (t2 > 0) && (sj < t2) && (sj <= t1);
    endfunction

    task automatic model_reset();
        m_sh = c_rst; m_act = c_rst;
        m_pend = 0; m_err = 0; m_bus = 0; m_rec = 0;
        m_state = 0; m_run = 0; m_seq = 0;
    endtask

    task automatic model_step();
        type_reg2tim_s n_sh, n_act;
        bit n_pend, n_bus, n_rec, ok, safe;
        int n_state, n_run, n_seq;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n_sh = m_sh; n_act = m_act; n_pend = m_pend; n_bus = m_bus; n_rec = 0;
        n_state = m_state; n_run = m_run; n_seq = m_seq;
        ok   = cfg_wr && legal(cfg);
        safe = (m_state == 0) || reset_mode || (sp && rx_idle && !tx);
        if (m_pend && safe) begin
            n_act = m_sh;
            n_pend = 0;
        end
        if (ok) begin
            n_sh = cfg;
            if (m_state == 0) begin
                n_act = cfg;
                n_pend = 0;
            end else begin
                n_pend = 1;
            end
        end
        if (reset_mode) begin
            n_state = 0; n_bus = 0; n_run = 0; n_seq = 0;
        end else begin
            case (m_state)
                0: begin n_state = 1; n_run = 0; n_seq = 0; end
                1, 3: if (sp) begin
                    n_run = sbit ? m_run + 1 : 0;
                    if (n_run == INTEG) begin
                        n_run = 0;
                        if (m_state == 1) begin
                            n_state = 2; n_bus = 1;
                        end else begin
                            n_seq = m_seq + 1;
                            if (n_seq == RECOV) begin
                                n_state = 2; n_bus = 1; n_rec = 1;
                            end
                        end
                    end
                end
                default: if (bus_off) begin
                    n_state = 3; n_bus = 0; n_run = 0; n_seq = 0;
                end
            endcase
        end
        m_err = cfg_wr && !ok;
        m_sh = n_sh; m_act = n_act; m_pend = n_pend; m_bus = n_bus; m_rec = n_rec;
        m_state = n_state; m_run = n_run; m_seq = n_seq;
    endtask

    task automatic compare_all();
        check("reg2tim",   {17'd0, reg2tim_o}, {17'd0, m_act});
        check("pending",   32'(cfg_pending_o), 32'(m_pend));
        check("cfg_err",   32'(cfg_err_o),     32'(m_err));
        check("bus_on",    32'(bus_on_o),      32'(m_bus));
        check("recovered", 32'(recovered_o),   32'(m_rec));
        check("state",     32'(state_o),       32'(m_state));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        cfg_wr = 1'b0;
        sp     = 1'b0;
    endtask

    task automatic smp(input bit b);
        sp = 1'b1;
        sbit = b;
        tick();
    endtask

    task automatic write_cfg(input logic [3:0] t1, input logic [2:0] t2,
                             input logic [1:0] sj, input logic [5:0] brp);
        cfg = {t1, t2, sj, brp};
        cfg_wr = 1'b1;
        tick();
    endtask

    // One full recessive run, sometimes preceded by a partial run broken by a dominant bit
    task automatic one_run();
        if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 10)) smp(1'b1);
            smp(1'b0);
        end
        repeat (INTEG - 1) smp(1'b1);
        if ($urandom_range(0, 3) == 0) tick();
        smp(1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_reg2tim", {17'd0, reg2tim_o}, {17'd0, c_rst});
        check("async_state",   32'(state_o), 32'd0);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        c_rst = {4'd5, 3'd2, 2'd0, 6'd4};
        rst_n = 1'b1; cfg_wr = 1'b0; cfg = '0; reset_mode = 1'b1;
        bus_off = 1'b0; rx_idle = 1'b0; tx = 1'b0; sp = 1'b0; sbit = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write in reset mode takes effect directly
        write_cfg(4'd7, 3'd3, 2'd1, 6'd9);
        check("rm_write", {17'd0, reg2tim_o}, {17'd0, 4'd7, 3'd3, 2'd1, 6'd9});
        check("rm_pending", 32'(cfg_pending_o), 32'd0);

        // Rejected writes
        write_cfg(4'd7, 3'd0, 2'd0, 6'd1);
        check("err_tseg2_0", 32'(cfg_err_o), 32'd1);
        tick();
        write_cfg(4'd7, 3'd2, 2'd2, 6'd1);
        check("err_sjw_eq_tseg2", 32'(cfg_err_o), 32'd1);
        check("err_keep", {17'd0, reg2tim_o}, {17'd0, 4'd7, 3'd3, 2'd1, 6'd9});
        tick();

        // Integration: 10 recessive, 1 dominant, 11 recessive
        reset_mode = 1'b0;
        tick();
        repeat (10) smp(1'b1);
        smp(1'b0);
        repeat (10) smp(1'b1);
        check("bus_on_pre22", 32'(bus_on_o), 32'd0);
        smp(1'b1);
        check("bus_on_22", 32'(bus_on_o), 32'd1);
        check("state_active", 32'(state_o), 32'd2);

        // Pending held while transmitting, committed at an idle sample point
        rx_idle = 1'b1; tx = 1'b1;
        write_cfg(4'd5, 3'd2, 2'd1, 6'd3);
        smp(1'b1);
        check("pend_hold", 32'(cfg_pending_o), 32'd1);
        tx = 1'b0;
        smp(1'b1);
        check("commit", {17'd0, reg2tim_o}, {17'd0, 4'd5, 3'd2, 2'd1, 6'd3});
        check("commit_pend", 32'(cfg_pending_o), 32'd0);

        // Bus-off recovery: 127 runs do not recover, the 128th does
        rx_idle = 1'b0;
        bus_off = 1'b1;
        tick();
        bus_off = 1'b0;
        for (int r = 0; r < RECOV - 1; r++) one_run();
        check("no_recover_127", 32'(state_o), 32'd3);
        repeat (INTEG - 1) smp(1'b1);
        check("no_recover_pulse", 32'(recovered_o), 32'd0);
        smp(1'b1);
        check("recovered", 32'(recovered_o), 32'd1);
        check("recovered_bus_on", 32'(bus_on_o), 32'd1);
        tick();

        // Reset mode during recovery with a pending write commits it
        bus_off = 1'b1;
        tick();
        bus_off = 1'b0;
        tx = 1'b1;
        write_cfg(4'd9, 3'd4, 2'd2, 6'd7);
        repeat (5) smp(1'b1);
        reset_mode = 1'b1;
        tick();
        check("rm_state", 32'(state_o), 32'd0);
        check("rm_commit", {17'd0, reg2tim_o}, {17'd0, 4'd9, 3'd4, 2'd2, 6'd7});
        check("rm_bus_on", 32'(bus_on_o), 32'd0);
        reset_mode = 1'b0;
        tick();
        repeat (INTEG) smp(1'b1);

        // Async reset while a write is pending
        write_cfg(4'd3, 3'd3, 2'd1, 6'd2);
        async_reset();
        tick();

        // Randomized traffic
        tx = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) reset_mode = ~reset_mode;
            cfg_wr  = ($urandom_range(0, 7) == 0);
            cfg     = type_reg2tim_s'($urandom_range(0, 32767));
            bus_off = ($urandom_range(0, 99) == 0);
            rx_idle = $urandom_range(0, 1) != 0;
            tx      = ($urandom_range(0, 2) == 0);
            sp      = $urandom_range(0, 1) != 0;
            sbit    = ($urandom_range(0, 19) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/can_btr_ctrl.md
Name: can_btr_ctrl

Overview:
- Bit-timing configuration and bus-integration controller sitting between the host register file and the CAN bit-timing block.
- Validates host writes of timing fields and holds them in a shadow register.
- Drives the active type_reg2tim_s configuration, committing a new value only in reset mode or at a safe idle sample point.
- Sequences bus-on: 11-recessive-bit integration after reset mode, and the 128x11 bus-off recovery.

Parameters:
- INTEG_BITS, 11, consecutive recessive sampled bits required for integration.
- RECOVERY_SEQS, 128, INTEG_BITS-long recessive runs required to leave bus-off.
- RST_TSEG1, 4'd5, reset value of active/shadow tseg1.
- RST_TSEG2, 3'd2, reset value of active/shadow tseg2.
- RST_SJW, 2'd0, reset value of active/shadow sjw.
- RST_BRP, 6'd4, reset value of active/shadow baud_prescaler.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr_i  in  1  host write strobe, one cycle
- cfg_i  in  type_reg2tim_s  requested tseg1[3:0], tseg2[2:0], sjw[1:0], baud_prescaler[5:0]
- reset_mode_i  in  1  controller reset-mode bit from the mode register
- bus_off_i  in  1  bus-off indication from the error counters (level)
- rx_idle_i  in  1  receiver idle
- transmitting_i  in  1  node currently driving a frame
- sample_point_i  in  1  one-cycle sample strobe from the timing block
- sampled_bit_i  in  1  bit captured at the sample point, 1 = recessive
- reg2tim_o  out  type_reg2tim_s  active timing configuration
- cfg_pending_o  out  1  shadow differs from active and is awaiting commit
- cfg_err_o  out  1  one-cycle pulse, last write rejected
- bus_on_o  out  1  node may participate on the bus
- recovered_o  out  1  one-cycle pulse on bus-off recovery completion
- state_o  out  2  current FSM state, for status registers

Behaviour:
- Reset values:
  - reg2tim_o and shadow = RST_* values.
  - cfg_pending_o = 0, cfg_err_o = 0.
  - bus_on_o = 0, recovered_o = 0.
  - state = RESET_MODE.
  - run_cnt = 0, seq_cnt = 0.
- Validation: a write is valid iff tseg1 != 0, tseg2 != 0, sjw < tseg2, and sjw <= tseg1. All comparisons are unsigned at field width, with sjw zero-extended.
- Invalid write:
  - cfg_err_o = 1 in the next cycle.
  - Shadow, active and pending are unchanged.
- Valid write in RESET_MODE: shadow and reg2tim_o both updated in the next cycle; cfg_pending_o stays 0.
- Valid write in any other state:
  - Shadow updated in the next cycle; cfg_pending_o = 1.
  - A later valid write overwrites the shadow; last write wins.
- Commit while pending, state != RESET_MODE:
  - Condition: sample_point_i & rx_idle_i & ~transmitting_i.
  - Next cycle: reg2tim_o <= shadow and cfg_pending_o <= 0.
  - If a valid write coincides with the commit cycle, the new write is taken into the shadow and pending stays 1; the old shadow commits.
- Entering RESET_MODE with pending = 1 commits the shadow immediately.
- FSM states are RESET_MODE = 0, INTEGRATE = 1, ACTIVE = 2, BUS_OFF_RECOVER = 3.
  - reset_mode_i = 1 forces RESET_MODE from any state, with priority over everything else. It clears run_cnt, seq_cnt and bus_on_o.
  - RESET_MODE -> INTEGRATE when reset_mode_i = 0; run_cnt = 0.
  - INTEGRATE:
    - On sample_point_i, a recessive bit increments run_cnt; a dominant bit clears it.
    - When a recessive sample makes run_cnt reach INTEG_BITS, go to ACTIVE; bus_on_o = 1 in that same next cycle.
  - ACTIVE:
    - bus_off_i = 1 -> BUS_OFF_RECOVER next cycle; bus_on_o = 0; run_cnt and seq_cnt cleared.
    - run_cnt is idle in this state.
  - BUS_OFF_RECOVER:
    - run_cnt counts as in INTEGRATE.
    - When run_cnt reaches INTEG_BITS, run_cnt goes to 0 and seq_cnt increments.
    - A dominant bit clears run_cnt only.
    - When seq_cnt reaches RECOVERY_SEQS, go to ACTIVE; recovered_o is a one-cycle pulse; bus_on_o = 1.
    - bus_off_i is ignored in this state.
- Counter widths are $clog2(INTEG_BITS+1) and $clog2(RECOVERY_SEQS+1). Counters saturate, never wrap.
- sample_point_i arriving while cfg_wr_i is high: both are handled in the same cycle, independently.
- Asynchronous reset mid-recovery or mid-pending returns everything to the reset values, including reg2tim_o = RST_*.

Decomposition:
- can_defs package:
  - type_reg2tim_s (already shared).
  - New enum type_btr_state_e for the four states.
  - Constants CAN_INTEG_BITS = 11 and CAN_RECOVERY_SEQS = 128, used as parameter defaults.
- One sub-module, can_recessive_run_cnt:
  - Inputs: sample strobe, bit, clear.
  - Output: a one-cycle run_done pulse at INTEG_BITS.
  - Reused by INTEGRATE and BUS_OFF_RECOVER; the FSM and the shadow/commit logic stay in can_btr_ctrl.

Test Plan:
- Reset, then write in RESET_MODE {tseg1=7, tseg2=3, sjw=1, brp=9} -> reg2tim_o equals it one cycle later, cfg_pending_o = 0, cfg_err_o = 0.
- Writes {tseg2=0} and {tseg2=2, sjw=2} -> cfg_err_o pulses once per write; reg2tim_o and shadow unchanged.
- Drop reset_mode_i, drive 10 recessive samples, 1 dominant, then 11 recessive -> bus_on_o rises exactly after the 22nd sample, state_o = 2.
- In ACTIVE, a valid write with transmitting_i = 1 -> pending holds. Then rx_idle_i = 1, transmitting_i = 0 and a sample point -> reg2tim_o updates next cycle, pending = 0.
- Assert bus_off_i, then 128 runs of 11 recessive bits with dominant bits sprinkled mid-run -> recovered_o pulses once after run 128, bus_on_o = 1; with only 127 runs, no recovery.
- Assert reset_mode_i during BUS_OFF_RECOVER with pending = 1 -> state 0 next cycle, shadow committed, bus_on_o = 0, counters 0. Async rst_n pulse mid-operation -> all outputs at RST_* and reset values.
